// File: rtl/glyph_rom_if.sv
// ============================================================================
// Module      : glyph_rom_if
// Description : Request/acknowledge read bus between glyph_fetch and the
//               glyph ROM (11-bit address, 8-bit row data).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface glyph_rom_if;
    logic        req;
    logic [10:0] addr;
    logic        ack;
    logic [7:0]  data;

    modport master (
        output req,
        output addr,
        input  ack,
        input  data
    );

    modport slave (
        input  req,
        input  addr,
        output ack,
        output data
    );
endinterface

`default_nettype wire

// File: rtl/glyph_fetch.sv
// ============================================================================
// Module      : glyph_fetch
// Description : Double-buffered 16x8 glyph fetcher with registered pixel
//               output. Optional flash generator enabled by FLASH_GEN_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module glyph_fetch #(
    parameter int FLASH_FRAMES = 30
) (
    input  wire logic       clk_i,
    input  wire logic       rst_ni,
    input  wire logic       read_en_i,
    input  wire logic [6:0] char_code_i,
    input  wire logic [3:0] row_cnt_i,
    input  wire logic [2:0] col_cnt_i,
    glyph_rom_if.master     rom,
    output logic            bit_disp_o,
    output logic            busy_o,
    output logic            overrun_o,
    output logic            flash_clk_o
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FETCH = 1'b1
    } state_t;

    state_t      state_q;
    logic [6:0]  code_q;
    logic [3:0]  row_q;
    logic        req_q;
    logic [10:0] addr_q;
    logic [7:0]  active_q [16];
    logic [7:0]  shadow_q [16];
    logic        shadow_valid_q;
    logic        bit_disp_q;
    logic        overrun_q;
    logic [3:0]  row_d;

    assign row_d = row_q + 4'd1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= ST_IDLE;
            code_q         <= '0;
            row_q          <= '0;
            req_q          <= 1'b0;
            addr_q         <= '0;
            active_q       <= '{default: '0};
            shadow_q       <= '{default: '0};
            shadow_valid_q <= 1'b0;
            bit_disp_q     <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            overrun_q  <= 1'b0;
            // Reads the pre-swap buffer because the swap below is non-blocking.
            bit_disp_q <= active_q[row_cnt_i][~col_cnt_i];
            case (state_q)
                ST_IDLE: begin
                    if (read_en_i) begin
                        if (shadow_valid_q) begin
                            active_q       <= shadow_q;
                            shadow_valid_q <= 1'b0;
                        end
                        code_q  <= char_code_i;
                        row_q   <= 4'd0;
                        req_q   <= 1'b1;
                        addr_q  <= {char_code_i, 4'd0};
                        state_q <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (read_en_i) begin
                        overrun_q <= 1'b1;
                    end
                    if (rom.ack) begin
                        shadow_q[row_q] <= rom.data;
                        if (row_q == 4'd15) begin
                            shadow_valid_q <= 1'b1;
                            req_q          <= 1'b0;
                            state_q        <= ST_IDLE;
                        end else begin
                            row_q  <= row_d;
                            addr_q <= {code_q, row_d};
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign rom.req    = req_q;
    assign rom.addr   = addr_q;
    assign bit_disp_o = bit_disp_q;
    assign overrun_o  = overrun_q;
    assign busy_o     = (state_q == ST_FETCH);

`ifdef FLASH_GEN_EN
    localparam int             CNT_W = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
    localparam logic [CNT_W-1:0] LAST_FRAME = CNT_W'(FLASH_FRAMES - 1);

    logic [CNT_W-1:0] frame_q;
    logic             flash_q;

    // Every readEn counts as a frame, whether or not it starts a fetch.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            frame_q <= '0;
            flash_q <= 1'b0;
        end else if (read_en_i) begin
            if (frame_q == LAST_FRAME) begin
                frame_q <= '0;
                flash_q <= ~flash_q;
            end else begin
                frame_q <= frame_q + CNT_W'(1);
            end
        end
    end

    assign flash_clk_o = flash_q;
`else
    // Constant zero; the parameter is referenced so it stays visible to tools.
    assign flash_clk_o = 1'b0 & (FLASH_FRAMES == 0);
`endif

endmodule

`default_nettype wire

// File: tb/tb_glyph_fetch.sv
// ============================================================================
// Module      : tb_glyph_fetch
// Description : Scoreboard bench for glyph_fetch: ROM addresses are queued
//               when a fetch is launched and popped as the ROM acknowledges.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_glyph_fetch;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       read_en = 1'b0;
    logic [6:0] char_code = '0;
    logic [3:0] row_cnt = '0;
    logic [2:0] col_cnt = '0;
    logic       bit_disp;
    logic       busy;
    logic       overrun;
    logic       flash_clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int start_cyc = 0;

    int   lat = 0;
    int   wcnt = 0;
    logic rom_const = 1'b1;
    logic ack_stray = 1'b0;

    logic [10:0] exp_q [$];
    logic [7:0]  exp_active [16];
    logic [7:0]  exp_shadow [16];
    logic        exp_sv = 1'b0;
    logic [6:0]  exp_code = '0;

`ifdef FLASH_GEN_EN
    localparam logic FLASH_ON = 1'b1;
`else
    localparam logic FLASH_ON = 1'b0;
`endif

    glyph_rom_if u_rom ();

    glyph_fetch #(.FLASH_FRAMES(4)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .read_en_i   (read_en),
        .char_code_i (char_code),
        .row_cnt_i   (row_cnt),
        .col_cnt_i   (col_cnt),
        .rom         (u_rom),
        .bit_disp_o  (bit_disp),
        .busy_o      (busy),
        .overrun_o   (overrun),
        .flash_clk_o (flash_clk)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ROM model: acknowledges after lat extra wait cycles per address.
    always @(posedge clk) begin
        if (!u_rom.req || u_rom.ack) wcnt <= 0;
        else                         wcnt <= wcnt + 1;
    end
    assign u_rom.ack  = (u_rom.req && (wcnt == lat)) || ack_stray;
    assign u_rom.data = rom_const ? 8'hA5 : (u_rom.addr[7:0] ^ 8'h3C);

    function automatic logic [7:0] rom_fn(input logic [10:0] a);
        if (rom_const) return 8'hA5;
        return a[7:0] ^ 8'h3C;
    endfunction

    // Scoreboard: every cycle with romReq high must show the queued address.
    always @(negedge clk) begin
        if (rst_n && u_rom.req) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL rom_req_unexpected: romReq=1 addr=%h, expected no request", u_rom.addr);
            end else begin
                if (u_rom.addr !== exp_q[0]) begin
                    miscompares++;
                    $display("FAIL rom_addr: got %h, expected %h", u_rom.addr, exp_q[0]);
                end
                if (u_rom.ack) void'(exp_q.pop_front());
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        read_en = 1'b0;
        exp_q.delete();
        exp_active = '{default: '0};
        exp_shadow = '{default: '0};
        exp_sv = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic start_fetch(input logic [6:0] code);
        if (exp_sv) begin
            exp_active = exp_shadow;
            exp_sv = 1'b0;
        end
        for (int r = 0; r < 16; r++) exp_q.push_back({code, 4'(r)});
        exp_code = code;
        @(negedge clk);
        read_en   = 1'b1;
        char_code = code;
        @(negedge clk);
        read_en   = 1'b0;
        start_cyc = cyc;
        vectors++;
        if (busy !== 1'b1 || u_rom.req !== 1'b1) begin
            miscompares++;
            $display("FAIL fetch_start: busy=%b romReq=%b, expected 1 1", busy, u_rom.req);
        end
    endtask

    task automatic wait_done(input int exp_cycles);
        while (busy === 1'b1 && (cyc - start_cyc) < 500) @(negedge clk);
        vectors++;
        if ((cyc - start_cyc) !== exp_cycles || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL fetch_cycles: got %0d (busy=%b), expected %0d", cyc - start_cyc, busy, exp_cycles);
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL rows_left: got %0d, expected 0", exp_q.size());
        end
        for (int r = 0; r < 16; r++) exp_shadow[r] = rom_fn({exp_code, 4'(r)});
        exp_sv = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({busy, u_rom.req, u_rom.addr, bit_disp, overrun, flash_clk} !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_state: busy=%b req=%b addr=%h bit=%b ovr=%b flash=%b, expected all 0",
                     busy, u_rom.req, u_rom.addr, bit_disp, overrun, flash_clk);
        end
        ack_stray = 1'b1;
        repeat (3) @(negedge clk);
        ack_stray = 1'b0;
        vectors++;
        if (busy !== 1'b0 || u_rom.req !== 1'b0) begin
            miscompares++;
            $display("FAIL stray_ack: busy=%b req=%b, expected 0 0", busy, u_rom.req);
        end
    endtask

    task automatic test_zero_wait();
        rom_const = 1'b1;
        lat = 0;
        start_fetch(7'h41);
        wait_done(16);
        row_cnt = 4'd2;
        col_cnt = 3'd0;
        @(negedge clk);
        vectors++;
        if (bit_disp !== 1'b0) begin
            miscompares++;
            $display("FAIL no_first_swap: got %b, expected 0", bit_disp);
        end
        start_fetch(7'h41);
        wait_done(16);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            col_cnt = 3'(c);
            @(negedge clk);
            vectors++;
            if (bit_disp !== exp_active[2][7-c]) begin
                miscompares++;
                $display("FAIL pixel_col%0d: got %b, expected %b", c, bit_disp, exp_active[2][7-c]);
            end
        end
    endtask

    task automatic test_latency();
        rom_const = 1'b0;
        lat = 3;
        start_fetch(7'h12);
        wait_done(64);
    endtask

    task automatic test_swap_read();
        logic pre;
        lat = 0;
        row_cnt = 4'd0;
        col_cnt = 3'd0;
        pre = exp_active[0][7];
        start_fetch(7'h42);
        vectors++;
        if (bit_disp !== pre) begin
            miscompares++;
            $display("FAIL pre_swap_read: got %b, expected %b", bit_disp, pre);
        end
        @(negedge clk);
        vectors++;
        if (bit_disp !== exp_active[0][7]) begin
            miscompares++;
            $display("FAIL post_swap_read: got %b, expected %b", bit_disp, exp_active[0][7]);
        end
        wait_done(16);
    endtask

    task automatic test_overrun();
        int guard = 0;
        lat = 0;
        start_fetch(7'h33);
        while (u_rom.addr[3:0] != 4'd5 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        read_en   = 1'b1;
        char_code = 7'h7F;
        @(negedge clk);
        read_en = 1'b0;
        vectors++;
        if (overrun !== 1'b1) begin
            miscompares++;
            $display("FAIL overrun_pulse: got %b, expected 1", overrun);
        end
        @(negedge clk);
        vectors++;
        if (overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL overrun_width: got %b, expected 0", overrun);
        end
        wait_done(16);
        row_cnt = 4'd0;
        col_cnt = 3'd0;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (bit_disp !== exp_active[0][7]) begin
            miscompares++;
            $display("FAIL overrun_no_swap: got %b, expected %b", bit_disp, exp_active[0][7]);
        end
    endtask

    task automatic test_code_change();
        lat = 1;
        start_fetch(7'h41);
        repeat (5) @(negedge clk);
        char_code = 7'h42;
        wait_done(32);
    endtask

    task automatic test_reset_midfetch();
        int guard = 0;
        lat = 0;
        start_fetch(7'h55);
        while (u_rom.addr[3:0] != 4'd7 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (u_rom.req !== 1'b0 || busy !== 1'b0 || bit_disp !== 1'b0 || u_rom.addr !== 11'h0) begin
            miscompares++;
            $display("FAIL async_reset: req=%b busy=%b bit=%b addr=%h, expected 0 0 0 000",
                     u_rom.req, busy, bit_disp, u_rom.addr);
        end
        exp_q.delete();
        exp_active = '{default: '0};
        exp_shadow = '{default: '0};
        exp_sv = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        start_fetch(7'h55);
        wait_done(16);
        row_cnt = 4'd0;
        col_cnt = 3'd1;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (bit_disp !== exp_active[0][6]) begin
            miscompares++;
            $display("FAIL reset_active_clear: got %b, expected %b", bit_disp, exp_active[0][6]);
        end
    endtask

    task automatic test_flash();
        int   cnt = 0;
        logic exp_flash = 1'b0;
        do_reset();
        rom_const = 1'b0;
        lat = 0;
        for (int i = 1; i <= 8; i++) begin
            start_fetch(7'(8'h20 + i));
            cnt++;
            if (FLASH_ON && cnt == 4) begin
                cnt = 0;
                exp_flash = ~exp_flash;
            end
            vectors++;
            if (flash_clk !== exp_flash) begin
                miscompares++;
                $display("FAIL flash_pulse%0d: got %b, expected %b", i, flash_clk, exp_flash);
            end
            wait_done(16);
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_latency();
        test_swap_read();
        test_overrun();
        test_code_change();
        test_reset_midfetch();
        test_flash();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/glyph_fetch.md
GLYPH_FETCH -- requirements
Module: glyph_fetch

Interface
REQ-001 Parameter: FLASH_FRAMES, default 30, number of readEn pulses (frames) per flashClk half-period.
REQ-002 clock  in  1  single clock for all logic.
REQ-003 reset  in  1  asynchronous, active-low; asserting it clears all state immediately.
REQ-004 readEn  in  1  one-cycle frame-start pulse from the char stage; triggers buffer swap and next fetch.
REQ-005 charCode  in  7  ASCII code of the glyph to fetch; sampled only on an accepted readEn.
REQ-006 rowCnt  in  4  glyph row being displayed, 0..15.
REQ-007 colCnt  in  3  glyph column being displayed, 0..7, with 0 the leftmost pixel.
REQ-008 romReq  out  1  glyph ROM read request.
REQ-009 romAddr  out  11  ROM address {latched charCode, fetch row[3:0]}.
REQ-010 romAck  in  1  ROM data-valid strobe for the current request.
REQ-011 romData  in  8  glyph row bits, where bit 7 is column 0.
REQ-012 bitDisp  out  1  glyph pixel at (rowCnt, colCnt) of the active buffer.
REQ-013 busy  out  1  high while in FETCH.
REQ-014 overrun  out  1  one-cycle pulse when a readEn arrives during FETCH.
REQ-015 flashClk  out  1  flash phase for the char stage.

Function
REQ-016 Storage: two 16x8 glyph buffers, active and shadow, plus a shadowValid flag.
REQ-017 FSM states: IDLE and FETCH. Reset enters IDLE.
REQ-018 IDLE + readEn:
- if shadowValid, copy shadow to active in that same edge and clear shadowValid;
- latch charCode, set fetch row to 0, and enter FETCH.
REQ-019 FETCH behaviour:
- romReq is high and romAddr = {code, row};
- both hold stable until romAck is sampled high.
REQ-020 FETCH, romAck high:
- store romData in shadow[row];
- if row < 15, increment row and keep romReq high with the new address on the next cycle;
- if row == 15, set shadowValid, drop romReq, and return to IDLE.
REQ-021 Fetch time for a 16-row glyph: a zero-wait ROM (ack in the cycle after the address) completes in 16 cycles; longer ROM latency stretches it.
REQ-022 romAck sampled while romReq is low shall be ignored.
REQ-023 readEn during FETCH:
- no swap, no restart, and charCode is not sampled;
- the fetch continues to completion;
- overrun pulses high for exactly one cycle.
REQ-024 charCode changes during FETCH shall not affect romAddr.
REQ-025 bitDisp is registered, with 1-cycle latency: bitDisp(t+1) = active[rowCnt(t)][7 - colCnt(t)].
REQ-026 A swap and a bitDisp read on the same edge shall read the pre-swap active buffer.
REQ-027 The first readEn after reset swaps nothing, because shadowValid = 0; the glyph appears one frame after its fetch.
REQ-028 busy = (state == FETCH), driven combinationally from the state register.

Reset
REQ-029 Reset clears the following, including when it is asserted mid-fetch:
- state = IDLE, romReq = 0, romAddr = 0;
- both buffers to all-zero, shadowValid = 0;
- bitDisp = 0, overrun = 0, flashClk = 0, frame counter = 0.
REQ-030 After reset deassertion, the first readEn shall start a fresh fetch from row 0.

Configuration
REQ-031 Macro FLASH_GEN_EN defined: an internal frame counter increments on each readEn (accepted or not).
- On reaching FLASH_FRAMES-1 it wraps to 0 and flashClk toggles.
- flashClk is registered.
REQ-032 Macro FLASH_GEN_EN undefined: no counter is built and flashClk is tied to 0, so the glyph never blinks.

Verification
REQ-033 Reset low mid-fetch (row 7) -> romReq=0, busy=0 and bitDisp=0 immediately; the next readEn fetches from address {code,0}.
REQ-034 Zero-wait ROM returning 8'hA5 for every row, charCode=7'h41, two readEn pulses -> romAddr steps 0x410..0x41F; after the second readEn, bitDisp for colCnt 0..7 = 1,0,1,0,0,1,0,1.
REQ-035 ROM with 3-cycle ack latency -> romAddr held stable for each wait; fetch ends 64 cycles after readEn (16 rows x 4 cycles); shadowValid then set.
REQ-036 readEn pulse at fetch row 5 -> overrun is a single 1-cycle pulse, the fetch still reaches row 15, and active is unchanged.
REQ-037 charCode toggled 0x41->0x42 mid-fetch -> all 16 addresses keep prefix 0x41.
REQ-038 FLASH_GEN_EN with FLASH_FRAMES=4 and 8 readEn pulses -> flashClk toggles after the 4th and 8th pulse; without the macro, flashClk stays 0.
